// File: rtl/barrier_release_sequencer.sv
// barrier_release_sequencer: buffers barrier retire events and releases their wavefronts one per handshake, lowest wfid first.
module barrier_release_sequencer #(
  parameter int WF_PER_CU = 40,
  parameter int WFID_W    = 6,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 barrier_retire_en,
  input  logic [WF_PER_CU-1:0] barrier_retire_wf_bitmap,
  input  logic [31:0]          barrier_retire_pc,
  output logic                 rel_valid,
  input  logic                 rel_ready,
  output logic [WFID_W-1:0]    rel_wfid,
  output logic [31:0]          rel_pc,
  output logic                 rel_last,
  output logic                 seq_full,
  output logic                 seq_idle,
  output logic                 overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, DRAIN} state_e;
  state_e                state_q;
  logic [AW:0]           cnt_q;
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [WF_PER_CU-1:0]  work_bm_q, fbm_q [DEPTH];
  logic [31:0]           work_pc_q, fpc_q [DEPTH];
  logic                  ovf_q;
  logic                  drain, empty, full, last, accept, pop, evt, push;
  logic [WF_PER_CU-1:0]  rest_bm;
  logic [WFID_W-1:0]     wfid;
  assign drain   = state_q == DRAIN;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == DEPTH_C;
  assign rest_bm = work_bm_q & (work_bm_q - WF_PER_CU'(1));
  assign last    = drain & ~|rest_bm;
  assign accept  = drain & rel_ready;
  // A pop on the final accept of an event loads the next one with no bubble.
  assign pop     = ~empty & (~drain | (accept & last));
  assign evt     = barrier_retire_en & |barrier_retire_wf_bitmap;
  assign push    = evt & (~full | pop);
  always_comb begin
    wfid = '0;
    for (int i = WF_PER_CU - 1; i >= 0; i--)
      if (work_bm_q[i]) wfid = WFID_W'(i);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      work_bm_q <= '0;
      work_pc_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (evt & full & ~pop) ovf_q <= 1'b1;
      if (pop) begin
        work_bm_q <= fbm_q[rptr_q];
        work_pc_q <= fpc_q[rptr_q];
        state_q   <= DRAIN;
      end else if (accept) begin
        work_bm_q <= rest_bm;
        if (last) state_q <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fbm_q[wptr_q] <= barrier_retire_wf_bitmap;
      fpc_q[wptr_q] <= barrier_retire_pc;
    end
  end
  assign rel_valid    = drain;
  assign rel_wfid     = wfid;
  assign rel_pc       = drain ? work_pc_q : '0;
  assign rel_last     = last;
  assign seq_full     = full;
  assign seq_idle     = empty & ~drain;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_barrier_release_sequencer.sv
// tb_barrier_release_sequencer: directed checks of barrier_release_sequencer with hand-computed expectations.
module tb_barrier_release_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [39:0] bm = '0;
  logic [31:0] pc = '0;
  logic        rel_ready = 1'b0;
  logic        rel_valid, rel_last, seq_full, seq_idle, overflow_err;
  logic [5:0]  rel_wfid;
  logic [31:0] rel_pc;
  int          n_run = 0;
  int          n_fail = 0;
  barrier_release_sequencer dut (
    .clk(clk), .rst(rst), .barrier_retire_en(en), .barrier_retire_wf_bitmap(bm),
    .barrier_retire_pc(pc), .rel_valid(rel_valid), .rel_ready(rel_ready),
    .rel_wfid(rel_wfid), .rel_pc(rel_pc), .rel_last(rel_last), .seq_full(seq_full),
    .seq_idle(seq_idle), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [39:0] b, input logic [31:0] p);
    en = 1'b1;
    bm = b;
    pc = p;
    step();
    en = 1'b0;
    bm = '0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask
  localparam logic [39:0] B3739 = 40'h80_0000_0088;
  int exp_ids [3] = '{3, 7, 39};
  logic rdy_seq [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  initial begin
    do_reset();
    chk("rst_valid", rel_valid, 0);
    chk("rst_idle", seq_idle, 1);
    chk("rst_full", seq_full, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_wfid", rel_wfid, 0);
    chk("rst_pc", rel_pc, 0);
    chk("rst_last", rel_last, 0);
    rel_ready = 1'b1;
    pulse(B3739, 32'h100);
    chk("lat_t1_valid", rel_valid, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("basic_valid", rel_valid, 1);
      chk("basic_wfid", rel_wfid, exp_ids[i]);
      chk("basic_pc", rel_pc, 32'h100);
      chk("basic_last", rel_last, i == 2);
      step();
    end
    chk("basic_end_valid", rel_valid, 0);
    chk("basic_end_idle", seq_idle, 1);
    rel_ready = 1'b0;
    pulse(B3739, 32'h100);
    step();
    begin
      int k = 0;
      for (int i = 0; i < 6; i++) begin
        rel_ready = rdy_seq[i];
        chk("stall_valid", rel_valid, 1);
        chk("stall_wfid", rel_wfid, exp_ids[k]);
        chk("stall_pc", rel_pc, 32'h100);
        chk("stall_last", rel_last, k == 2);
        if (rdy_seq[i]) k++;
        step();
      end
    end
    chk("stall_end_valid", rel_valid, 0);
    rel_ready = 1'b1;
    pulse(40'h3, 32'h10);
    pulse(40'h20, 32'h20);
    chk("b2b_wfid0", rel_wfid, 0);
    chk("b2b_pc0", rel_pc, 32'h10);
    chk("b2b_last0", rel_last, 0);
    step();
    chk("b2b_wfid1", rel_wfid, 1);
    chk("b2b_last1", rel_last, 1);
    chk("b2b_pc1", rel_pc, 32'h10);
    step();
    chk("b2b_valid5", rel_valid, 1);
    chk("b2b_wfid5", rel_wfid, 5);
    chk("b2b_pc5", rel_pc, 32'h20);
    chk("b2b_last5", rel_last, 1);
    step();
    chk("b2b_end_valid", rel_valid, 0);
    chk("b2b_end_idle", seq_idle, 1);
    pulse(40'h0, 32'h55);
    chk("zero_idle", seq_idle, 1);
    chk("zero_ovf", overflow_err, 0);
    step();
    chk("zero_valid", rel_valid, 0);
    rel_ready = 1'b0;
    pulse(40'h2, 32'h1);
    pulse(40'h4, 32'h2);
    pulse(40'h8, 32'h3);
    chk("ovf_full", seq_full, 1);
    chk("ovf_wfid_head", rel_wfid, 1);
    chk("ovf_pre_err", overflow_err, 0);
    pulse(40'h10, 32'h4);
    chk("ovf_err", overflow_err, 1);
    chk("ovf_full2", seq_full, 1);
    rel_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("ovf_valid", rel_valid, 1);
      chk("ovf_wfid", rel_wfid, i);
      chk("ovf_pc", rel_pc, i);
      step();
    end
    chk("ovf_dropped_valid", rel_valid, 0);
    chk("ovf_end_idle", seq_idle, 1);
    chk("ovf_sticky", overflow_err, 1);
    do_reset();
    chk("ovf_cleared", overflow_err, 0);
    rel_ready = 1'b0;
    pulse(40'h2, 32'h1);
    pulse(40'h4, 32'h2);
    pulse(40'h8, 32'h3);
    chk("sim_full", seq_full, 1);
    rel_ready = 1'b1;
    pulse(40'h10, 32'h4);
    chk("sim_no_err", overflow_err, 0);
    chk("sim_full_kept", seq_full, 1);
    for (int i = 2; i <= 4; i++) begin
      chk("sim_wfid", rel_wfid, i);
      chk("sim_pc", rel_pc, i);
      chk("sim_last", rel_last, 1);
      step();
    end
    chk("sim_end_valid", rel_valid, 0);
    chk("sim_end_ovf", overflow_err, 0);
    pulse(B3739, 32'h100);
    step();
    chk("mid_wfid3", rel_wfid, 3);
    step();
    chk("mid_wfid7", rel_wfid, 7);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_valid", rel_valid, 0);
    chk("mid_idle", seq_idle, 1);
    chk("mid_pc", rel_pc, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_quiet", rel_valid, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/barrier_release_sequencer.md
Name: barrier_release_sequencer

Overview:
- Sits between the issue-stage barrier tracker and the wavepool/issue arbiter.
- Each time a workgroup's barrier completes, the tracker emits one retire pulse carrying the bitmap of waiting wavefronts and the barrier PC.
- This block buffers those events and releases the wavefronts one per handshake, lowest wfid first, so downstream logic sees at most one wavefront release per cycle.
- It raises a full indication that decode uses to stall further barrier instructions.

Parameters:
- WF_PER_CU, 40, number of wavefront slots per CU; width of the bitmap.
- WFID_W, 6, wfid width; must satisfy 2^WFID_W >= WF_PER_CU.
- DEPTH, 2, number of buffered retire events; must be a power of two and >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the rising clk edge).
- barrier_retire_en  in  1  single-cycle pulse: a barrier completed.
- barrier_retire_wf_bitmap  in  WF_PER_CU  wavefronts to release; sampled only when barrier_retire_en==1.
- barrier_retire_pc  in  32  barrier instruction PC; sampled with the bitmap.
- rel_valid  out  1  a release is presented.
- rel_ready  in  1  consumer accepts the presented release.
- rel_wfid  out  WFID_W  wavefront being released.
- rel_pc  out  32  PC of the barrier being retired.
- rel_last  out  1  the presented wfid is the final wavefront of the current event.
- seq_full  out  1  event FIFO holds DEPTH entries.
- seq_idle  out  1  FIFO empty and FSM in IDLE.
- overflow_err  out  1  sticky; set when an event was dropped.

Behaviour:
- Reset (rst==0 at posedge):
  - FIFO count, read pointer and write pointer cleared; working bitmap cleared; FSM goes to IDLE; overflow_err cleared.
  - After reset: rel_valid=0, rel_last=0, rel_wfid=0, rel_pc=0, seq_full=0, seq_idle=1.
  - Reset mid-drain discards all pending and in-flight releases; no partial release is completed.
- Enqueue:
  - An event is pushed when barrier_retire_en==1 and the bitmap is nonzero.
  - An event with a zero bitmap is ignored: no push, no error.
  - If the FIFO is full and no pop occurs that cycle, the event is dropped and overflow_err is set. overflow_err clears only on reset.
  - Push and pop in the same cycle with a full FIFO: the pop frees the slot, the push is accepted, count is unchanged and no error is raised.
- Pop: occurs in the cycle the FSM loads the working register (defined below). The FIFO never feeds the output combinationally.
- FSM has two states, IDLE and DRAIN.
  - IDLE, FIFO non-empty: pop the head into work_bitmap/work_pc; next state DRAIN.
  - IDLE, FIFO empty: stay in IDLE.
  - DRAIN outputs:
    - rel_valid=1.
    - rel_wfid = index of the lowest set bit of work_bitmap.
    - rel_pc = work_pc.
    - rel_last=1 iff exactly one bit of work_bitmap is set.
  - DRAIN, rel_valid & rel_ready: clear that bit.
  - DRAIN, accepted release with rel_last=1:
    - If the FIFO is non-empty: pop the next head into the working register in the same edge and stay in DRAIN. This gives back-to-back events with no bubble.
    - Else: go to IDLE.
  - DRAIN, rel_ready==0: hold all outputs stable, since the handshake is valid-before-ready. rel_valid never drops without acceptance.
- Latency: an event pulsed in cycle T into an empty FIFO with the FSM in IDLE:
  - FIFO write at the end of T.
  - Pop at the end of T+1.
  - rel_valid=1 in T+2.
  - With rel_ready held high, a bitmap of N bits gives N consecutive releases.
- seq_full = (count==DEPTH), registered from count.
- seq_idle = (count==0) & IDLE.
- Pointers wrap modulo DEPTH.
- The count is sized log2(DEPTH)+1 bits so that full and empty are distinguished.
- The wfid priority encoder covers all WF_PER_CU bits. Bits at or above WF_PER_CU do not exist.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> rel_valid=0, seq_idle=1, seq_full=0, overflow_err=0.
- Event with bitmap bits {3,7,39}, pc=0x100, in cycle T; rel_ready=1 -> rel_valid high in T+2..T+4 with wfid 3, 7, 39 in order; rel_pc=0x100; rel_last=1 only on wfid 39; seq_idle=1 at T+5.
- Same event with rel_ready toggling 0,1,0,0,1,1 -> wfid/pc/rel_last remain stable while ready=0; exactly 3 acceptances occur in order 3, 7, 39.
- Back-to-back events:
  - Event A={0,1} pc=0x10, then event B={5} pc=0x20 one cycle later; ready=1 -> releases 0, 1, 5 in consecutive cycles with no bubble between wfid 1 and wfid 5; pc changes to 0x20 on the wfid 5 release.
  - Event with a zero bitmap -> no push and no error.
- Overflow (DEPTH=2), ready=0:
  - Three events: the first pops to the working register, the next two fill the FIFO, so seq_full=1.
  - A fourth event -> overflow_err=1 and it is never released.
  - Fourth event in the same cycle as a pop -> accepted, overflow_err stays 0.
- Reset asserted mid-drain after one of three releases -> next cycle rel_valid=0, seq_idle=1; the remaining wfids are never released.
